dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb.sv | 130 +++++++++++++
 tb/tb_dmem_arb.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: round-robin arbiter letting a CPU port and a debug/loader port
// share one data memory. Writes complete in their grant cycle; reads block
// further grants until the read data returns MEM_LAT cycles later.
module dmem_arb #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    // CPU port
    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_GNT,
    output logic              C_RVALID,
    output logic [DATA_W-1:0] C_RDATA,
    // debug/loader port
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    // memory side
    output logic              M_WRITE,
    output logic              M_READ,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic              BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } state_t;

    // Port identifiers used for both the priority pointer and the read owner.
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // The counter starts at MEM_LAT-1 so the data cycle lands MEM_LAT cycles after M_READ.
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic       pri_q, pri_d;
    logic       owner_q, owner_d;
    logic [1:0] cnt_q, cnt_d;

    logic grant_c;
    logic grant_d;
    logic grant_any;
    logic grant_we;
    logic data_cycle;

    // Grant at most one requester while idle; PRI only breaks ties, and reset blanks all grants.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        if (RST_N && (state_q == IDLE)) begin
            if (C_REQ && (!D_REQ || (pri_q == PORT_C))) begin
                grant_c = 1'b1;
            end else if (D_REQ) begin
                grant_d = 1'b1;
            end
        end
    end

    assign grant_any  = grant_c | grant_d;
    assign grant_we   = grant_c ? C_WE : D_WE;
    assign data_cycle = RST_N && (state_q == RWAIT) && (cnt_q == 2'd0);

    // Next-state logic: flip priority on every grant, park in RWAIT for reads until the counter drains.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (grant_any) begin
                pri_d = grant_c ? PORT_D : PORT_C;
                if (!grant_we) begin
                    state_d = RWAIT;
                    owner_d = grant_c ? PORT_C : PORT_D;
                    cnt_d   = CNT_INIT;
                end
            end
        end else begin
            if (cnt_q != 2'd0) begin
                cnt_d = cnt_q - 2'd1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State registers; an asynchronous reset abandons any outstanding read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pri_q   <= PORT_C;
            owner_q <= PORT_C;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant and memory strobes are visible in the same cycle as the request.
    assign C_GNT   = grant_c;
    assign D_GNT   = grant_d;
    assign M_WRITE = grant_any &  grant_we;
    assign M_READ  = grant_any & ~grant_we;
    assign M_ADDR  = grant_c ? C_ADDR  : (grant_d ? D_ADDR  : '0);
    assign M_WDATA = grant_c ? C_WDATA : (grant_d ? D_WDATA : '0);

    // Read data is steered only to the port that issued the read, and is zero otherwise.
    assign C_RVALID = data_cycle && (owner_q == PORT_C);
    assign D_RVALID = data_cycle && (owner_q == PORT_D);
    assign C_RDATA  = C_RVALID ? M_RDATA : '0;
    assign D_RDATA  = D_RVALID ? M_RDATA : '0;
    assign BUSY     = RST_N && (state_q == RWAIT);

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: drives three arbiters (MEM_LAT = 1, 3, 4) with shared stimulus
// and checks them with directed scenarios plus a timestamp-based reference model.
module tb_dmem_arb;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NDUT = 3;

    logic          CLK;
    logic          RST_N;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata, m_rdata;

    logic [NDUT-1:0] c_gnt, c_rvalid, d_gnt, d_rvalid, m_write, m_read, busy;
    logic [DW-1:0]   c_rdata [NDUT];
    logic [DW-1:0]   d_rdata [NDUT];
    logic [DW-1:0]   m_wdata [NDUT];
    logic [AW-1:0]   m_addr  [NDUT];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_arb #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) u_dut (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .C_REQ   (c_req),
            .C_WE    (c_we),
            .C_ADDR  (c_addr),
            .C_WDATA (c_wdata),
            .C_GNT   (c_gnt[g]),
            .C_RVALID(c_rvalid[g]),
            .C_RDATA (c_rdata[g]),
            .D_REQ   (d_req),
            .D_WE    (d_we),
            .D_ADDR  (d_addr),
            .D_WDATA (d_wdata),
            .D_GNT   (d_gnt[g]),
            .D_RVALID(d_rvalid[g]),
            .D_RDATA (d_rdata[g]),
            .M_WRITE (m_write[g]),
            .M_READ  (m_read[g]),
            .M_ADDR  (m_addr[g]),
            .M_WDATA (m_wdata[g]),
            .M_RDATA (m_rdata),
            .BUSY    (busy[g])
        );
    end

    // 10 ns clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    // Each DUT is modelled by "when was the outstanding read granted": it is busy
    // for the MEM_LAT cycles after that, and the last of them is the data cycle.
    typedef struct packed {
        logic          cg, dg, mr, mw, crv, drv, bsy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, crd, drd;
    } exp_t;

    int cyc;
    bit rd_pend  [NDUT];
    int rd_cycle [NDUT];
    bit rd_owner [NDUT];
    bit pri      [NDUT];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic exp_t model_expect(input int k);
        exp_t e;
        int   win;
        bit   we;
        e = '0;
        if (RST_N !== 1'b1) return e;
        if (rd_pend[k]) begin
            e.bsy = 1'b1;
            if (cyc == rd_cycle[k] + lat_of(k)) begin
                if (rd_owner[k]) begin
                    e.drv = 1'b1;
                    e.drd = m_rdata;
                end else begin
                    e.crv = 1'b1;
                    e.crd = m_rdata;
                end
            end
        end else begin
            win = -1;
            if (c_req && d_req) win = pri[k] ? 1 : 0;
            else if (c_req)     win = 0;
            else if (d_req)     win = 1;
            if (win >= 0) begin
                we      = (win == 1) ? d_we : c_we;
                e.cg    = (win == 0);
                e.dg    = (win == 1);
                e.mw    = we;
                e.mr    = !we;
                e.addr  = (win == 1) ? d_addr : c_addr;
                e.wdata = (win == 1) ? d_wdata : c_wdata;
            end
        end
        return e;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc <= 0;
            for (int k = 0; k < NDUT; k++) begin
                rd_pend[k]  <= 1'b0;
                rd_cycle[k] <= 0;
                rd_owner[k] <= 1'b0;
                pri[k]      <= 1'b0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < NDUT; k++) begin
                exp_t e;
                e = model_expect(k);
                if (rd_pend[k] && (cyc == rd_cycle[k] + lat_of(k))) rd_pend[k] <= 1'b0;
                if (e.cg || e.dg) begin
                    pri[k] <= e.cg;
                    if (e.mr) begin
                        rd_pend[k]  <= 1'b1;
                        rd_cycle[k] <= cyc;
                        rd_owner[k] <= e.dg;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_rdata = $urandom;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        c_req = 1; c_we = 0; c_addr = 16'h1234; c_wdata = $urandom;
        d_req = 1; d_we = 1; d_addr = 16'h5678; d_wdata = $urandom;
        m_rdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if ({c_gnt[k], d_gnt[k], c_rvalid[k], d_rvalid[k], m_read[k], m_write[k], busy[k]} !== 7'b0
                    || m_addr[k] !== '0 || m_wdata[k] !== '0 || c_rdata[k] !== '0 || d_rdata[k] !== '0) begin
                    bad++;
                    $display("[TB] FAIL reset_outputs dut%0d ctl=%b addr=%h wdata=%h crd=%h drd=%h required all zero",
                             k, {c_gnt[k], d_gnt[k], c_rvalid[k], d_rvalid[k], m_read[k], m_write[k], busy[k]},
                             m_addr[k], m_wdata[k], c_rdata[k], d_rdata[k]);
                end
            end
        end
    endtask

    task automatic test_single_read();
        logic [DW-1:0] rd;
        do_reset();
        c_req = 1; c_we = 0; c_addr = 16'h0010;
        @(negedge CLK);
        total++;
        if ({c_gnt[0], d_gnt[0], m_read[0], m_write[0], busy[0]} !== 5'b10100 || m_addr[0] !== 16'h0010) begin
            bad++;
            $display("[TB] FAIL read_grant ctl=%b addr=%h required ctl=10100 addr=0010",
                     {c_gnt[0], d_gnt[0], m_read[0], m_write[0], busy[0]}, m_addr[0]);
        end
        tick();
        c_req = 0;
        rd = $urandom;
        m_rdata = rd;
        @(negedge CLK);
        total++;
        if ({c_rvalid[0], d_rvalid[0], busy[0], c_gnt[0], m_read[0]} !== 5'b10100 || c_rdata[0] !== rd) begin
            bad++;
            $display("[TB] FAIL read_data ctl=%b rdata=%h required ctl=10100 rdata=%h",
                     {c_rvalid[0], d_rvalid[0], busy[0], c_gnt[0], m_read[0]}, c_rdata[0], rd);
        end
        tick();
        @(negedge CLK);
        total++;
        if ({c_rvalid[0], busy[0]} !== 2'b00 || c_rdata[0] !== '0) begin
            bad++;
            $display("[TB] FAIL read_after rvalid=%b busy=%b rdata=%h required 0 0 0",
                     c_rvalid[0], busy[0], c_rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        int win;
        do_reset();
        c_req = 1; c_we = 1; d_req = 1; d_we = 1;
        for (int i = 0; i < 7; i++) begin
            c_addr = AW'($urandom); c_wdata = $urandom;
            d_addr = AW'($urandom); d_wdata = $urandom;
            win = i % 2;
            @(negedge CLK);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if ({c_gnt[k], d_gnt[k], m_write[k], m_read[k]} !== ((win == 1) ? 4'b0110 : 4'b1010)
                    || m_wdata[k] !== ((win == 1) ? d_wdata : c_wdata)
                    || m_addr[k]  !== ((win == 1) ? d_addr : c_addr)) begin
                    bad++;
                    $display("[TB] FAIL b2b_write dut%0d step%0d ctl=%b wdata=%h addr=%h required winner=%s",
                             k, i, {c_gnt[k], d_gnt[k], m_write[k], m_read[k]}, m_wdata[k], m_addr[k],
                             (win == 1) ? "D" : "C");
                end
            end
            tick();
        end
    endtask

    // Runs right after test_back_to_back, whose last grant went to C, so PRI points at D.
    task automatic test_single_port();
        d_req = 0;
        c_req = 1; c_we = 1;
        for (int i = 0; i < 4; i++) begin
            c_addr = AW'($urandom); c_wdata = $urandom;
            @(negedge CLK);
            for (int k = 0; k < NDUT; k++) begin
                total++;
                if ({c_gnt[k], d_gnt[k], m_write[k]} !== 3'b101 || m_wdata[k] !== c_wdata) begin
                    bad++;
                    $display("[TB] FAIL single_port dut%0d step%0d ctl=%b wdata=%h required ctl=101 wdata=%h",
                             k, i, {c_gnt[k], d_gnt[k], m_write[k]}, m_wdata[k], c_wdata);
                end
            end
            tick();
        end
        c_req = 0;
    endtask

    task automatic test_lat3_read();
        logic [DW-1:0] rd;
        do_reset();
        c_req = 1; c_we = 1; c_addr = 16'h0100; c_wdata = $urandom;
        tick();
        d_req = 1; d_we = 0; d_addr = 16'h0BEE;
        @(negedge CLK);
        total++;
        if ({c_gnt[1], d_gnt[1], m_read[1], m_write[1]} !== 4'b0110 || m_addr[1] !== 16'h0BEE) begin
            bad++;
            $display("[TB] FAIL lat3_grant ctl=%b addr=%h required ctl=0110 addr=0bee",
                     {c_gnt[1], d_gnt[1], m_read[1], m_write[1]}, m_addr[1]);
        end
        tick();
        d_req = 0;
        for (int j = 1; j <= 3; j++) begin
            rd = $urandom;
            m_rdata = rd;
            @(negedge CLK);
            total++;
            if ({c_gnt[1], d_gnt[1], m_read[1], m_write[1], c_rvalid[1], busy[1]} !== 6'b000001
                || d_rvalid[1] !== (j == 3) || d_rdata[1] !== ((j == 3) ? rd : '0)) begin
                bad++;
                $display("[TB] FAIL lat3_wait t+%0d ctl=%b drv=%b drd=%h required ctl=000001 drv=%0d",
                         j, {c_gnt[1], d_gnt[1], m_read[1], m_write[1], c_rvalid[1], busy[1]},
                         d_rvalid[1], d_rdata[1], (j == 3));
            end
            tick();
        end
        @(negedge CLK);
        total++;
        if ({c_gnt[1], d_gnt[1], m_write[1], busy[1], d_rvalid[1]} !== 5'b10100) begin
            bad++;
            $display("[TB] FAIL lat3_next ctl=%b required 10100",
                     {c_gnt[1], d_gnt[1], m_write[1], busy[1], d_rvalid[1]});
        end
        tick();
        c_req = 0;
    endtask

    task automatic test_reset_midread();
        do_reset();
        c_req = 1; c_we = 0; c_addr = 16'h0444;
        @(negedge CLK);
        total++;
        if ({c_gnt[2], m_read[2]} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL midrst_grant ctl=%b required 11", {c_gnt[2], m_read[2]});
        end
        tick();
        d_req = 1; d_we = 1;
        tick();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        total++;
        if ({c_gnt[2], d_gnt[2], c_rvalid[2], d_rvalid[2], m_read[2], m_write[2], busy[2]} !== 7'b0
            || m_addr[2] !== '0 || m_wdata[2] !== '0) begin
            bad++;
            $display("[TB] FAIL midrst_outputs ctl=%b addr=%h wdata=%h required all zero",
                     {c_gnt[2], d_gnt[2], c_rvalid[2], d_rvalid[2], m_read[2], m_write[2], busy[2]},
                     m_addr[2], m_wdata[2]);
        end
        repeat (2) @(posedge CLK);
        #1;
        c_req = 0; d_req = 0;
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            total++;
            if ({c_rvalid[2], d_rvalid[2], busy[2]} !== 3'b000) begin
                bad++;
                $display("[TB] FAIL midrst_stale step%0d ctl=%b required 000",
                         i, {c_rvalid[2], d_rvalid[2], busy[2]});
            end
            tick();
        end
        c_req = 1; c_we = 1; d_req = 1; d_we = 1;
        @(negedge CLK);
        total++;
        if ({c_gnt[2], d_gnt[2], m_write[2]} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL midrst_first ctl=%b required 101", {c_gnt[2], d_gnt[2], m_write[2]});
        end
        tick();
        @(negedge CLK);
        total++;
        if ({c_gnt[2], d_gnt[2], m_write[2]} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL midrst_second ctl=%b required 011", {c_gnt[2], d_gnt[2], m_write[2]});
        end
        tick();
        c_req = 0; d_req = 0;
    endtask

    task automatic test_dropped_req();
        do_reset();
        c_req = 1; c_we = 0; c_addr = 16'h0700;
        tick();
        c_req = 0;
        d_req = 1; d_we = 1; d_addr = 16'h0DDD; d_wdata = $urandom;
        for (int j = 1; j <= 6; j++) begin
            @(negedge CLK);
            total++;
            if ({d_gnt[2], c_gnt[2], m_read[2], m_write[2]} !== 4'b0000 || m_addr[2] !== '0
                || c_rvalid[2] !== (j == 4)) begin
                bad++;
                $display("[TB] FAIL dropped_req t+%0d ctl=%b addr=%h crv=%b required ctl=0000 addr=0 crv=%0d",
                         j, {d_gnt[2], c_gnt[2], m_read[2], m_write[2]}, m_addr[2], c_rvalid[2], (j == 4));
            end
            tick();
            d_req = 0;
        end
    endtask

    task automatic test_random();
        exp_t e, act;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            c_req   = ($urandom_range(0, 3) != 0);
            d_req   = ($urandom_range(0, 2) != 0);
            c_we    = $urandom_range(0, 1);
            d_we    = $urandom_range(0, 1);
            c_addr  = AW'($urandom);
            d_addr  = AW'($urandom);
            c_wdata = $urandom;
            d_wdata = $urandom;
            m_rdata = $urandom;
            @(negedge CLK);
            for (int k = 0; k < NDUT; k++) begin
                e = model_expect(k);
                act.cg    = c_gnt[k];
                act.dg    = d_gnt[k];
                act.mr    = m_read[k];
                act.mw    = m_write[k];
                act.crv   = c_rvalid[k];
                act.drv   = d_rvalid[k];
                act.bsy   = busy[k];
                act.addr  = m_addr[k];
                act.wdata = m_wdata[k];
                act.crd   = c_rdata[k];
                act.drd   = d_rdata[k];
                total++;
                if (act !== e) begin
                    bad++;
                    $display("[TB] FAIL random dut%0d cyc=%0d actual=%h required=%h", k, cyc, act, e);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_single_port();
        test_lat3_read();
        test_reset_midread();
        test_dropped_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
